// File: rtl/audio_sample_feeder_if.sv
// Producer-to-feeder sample write channel.
// Valid/ready handshake; a write occurs on WR_VALID & WR_READY.
interface audio_sample_feeder_if;
    logic [7:0] WR_DATA;
    logic       WR_VALID;
    logic       WR_READY;

    modport master (
        output WR_DATA,
        output WR_VALID,
        input  WR_READY
    );

    modport slave (
        input  WR_DATA,
        input  WR_VALID,
        output WR_READY
    );
endinterface

// File: rtl/audio_sample_feeder.sv
// Sample FIFO plus SCLK/LRCLK generation for the I2S serializer.
// One sample is popped per LRCLK rising edge and held for a frame.
module audio_sample_feeder #(
    parameter  int SCLK_DIV    = 4,
    parameter  int BITS_PER_CH = 32,
    parameter  int FIFO_DEPTH  = 16,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          EN,
    input  logic          CLR_UNDERFLOW,
    audio_sample_feeder_if.slave wr,
    output logic          SCLK,
    output logic          LRCLK,
    output logic [7:0]    SAMPLE,
    output logic [LW-1:0] FIFO_LEVEL,
    output logic          UNDERFLOW
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BW = $clog2(2 * BITS_PER_CH);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];

    logic div_wrap;
    logic sclk_fall;
    logic lr_nxt;
    logic pop;
    logic empty;
    logic wr_fire;
    logic pop_ok;

    // Frame position decode: the next bit slot and whether it pops.
    always_comb begin
        div_wrap  = (div_cnt == DW'(SCLK_DIV - 1));
        sclk_fall = EN && div_wrap && SCLK;
        bit_nxt   = (bit_cnt == BW'(2 * BITS_PER_CH - 1))
                  ? '0 : bit_cnt + BW'(1);
        lr_nxt    = (bit_nxt >= BW'(BITS_PER_CH));
        pop       = sclk_fall && !LRCLK && lr_nxt;
        empty     = (FIFO_LEVEL == '0);
        wr_fire   = wr.WR_VALID && wr.WR_READY;
        pop_ok    = pop && !empty;
    end

    assign wr.WR_READY = (FIFO_LEVEL < LW'(FIFO_DEPTH));

    // Bit and word clock generation; parked low while disabled.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            SCLK    <= 1'b0;
            LRCLK   <= 1'b0;
        end else if (!EN) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            SCLK    <= 1'b0;
            LRCLK   <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap) begin
                SCLK <= ~SCLK;
            end
            if (sclk_fall) begin
                bit_cnt <= bit_nxt;
                LRCLK   <= lr_nxt;
            end
        end
    end

    // Sample storage; written only on an accepted handshake.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_fire) begin
            mem[wr_ptr] <= wr.WR_DATA;
        end
    end

    // FIFO pointers and occupancy; an empty pop never bypasses a write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_fire, pop_ok})
                2'b10:   FIFO_LEVEL <= FIFO_LEVEL + LW'(1);
                2'b01:   FIFO_LEVEL <= FIFO_LEVEL - LW'(1);
                default: FIFO_LEVEL <= FIFO_LEVEL;
            endcase
        end
    end

    // Held sample output; silence on an empty pop.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            SAMPLE <= 8'h00;
        end else if (pop) begin
            SAMPLE <= empty ? 8'h00 : mem[rd_ptr];
        end
    end

    // Sticky underflow flag; a new underflow beats a clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            UNDERFLOW <= 1'b0;
        end else if (pop && empty) begin
            UNDERFLOW <= 1'b1;
        end else if (CLR_UNDERFLOW) begin
            UNDERFLOW <= 1'b0;
        end
    end

endmodule
